// File: rtl/prco_lsu.sv
// prco load/store initiator: one memory op in flight, req/ack memory port,
// valid/stalled/ce pipeline handshake towards writeback.
module prco_lsu #(
    parameter int unsigned P_TIMEOUT  = 64,
    parameter int unsigned P_RD_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_p_cp,
    input  logic                  i_p_valid,
    input  logic                  i_p_stalled,
    input  logic                  i_p_ce,
    output logic                  q_p_valid,
    output logic                  q_p_stalled,
    output logic                  q_p_ce,
    input  logic                  i_op_en,
    input  logic                  i_op_we,
    input  logic [15:0]           i_op_addr,
    input  logic [15:0]           i_op_data,
    input  logic [P_RD_WIDTH-1:0] i_op_rd,
    output logic                  q_mem_req,
    output logic                  q_mem_we,
    output logic [15:0]           q_mem_addr,
    output logic [15:0]           q_mem_dina,
    input  logic                  i_mem_ack,
    input  logic [15:0]           i_mem_douta,
    output logic                  q_wb_we,
    output logic [P_RD_WIDTH-1:0] q_wb_rd,
    output logic [15:0]           q_wb_data,
    output logic                  q_err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [7:0] LP_CNT_LAST = 8'(P_TIMEOUT - 1);

    state_t                  state;
    logic [7:0]              cnt;
    logic                    flush_pend;
    logic [P_RD_WIDTH-1:0]   op_rd;
    logic                    capture;
    logic                    req_end;

    assign q_p_stalled = (q_p_valid && i_p_stalled) || (state != S_IDLE);
    assign q_p_ce      = i_p_valid && !q_p_stalled;
    // a flushed upstream op is offered but never latched
    assign capture     = q_p_ce && !i_p_cp;
    assign req_end     = i_mem_ack || (cnt == LP_CNT_LAST);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            flush_pend    <= 1'b0;
            op_rd         <= '0;
            q_p_valid     <= 1'b0;
            q_mem_req     <= 1'b0;
            q_mem_we      <= 1'b0;
            q_mem_addr    <= '0;
            q_mem_dina    <= '0;
            q_wb_we       <= 1'b0;
            q_wb_rd       <= '0;
            q_wb_data     <= '0;
            q_err_timeout <= 1'b0;
        end else begin
            // consumption or flush clears the result; a completion below overrides
            if (i_p_cp || i_p_ce) begin
                q_p_valid <= 1'b0;
                q_wb_we   <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (capture) begin
                        op_rd      <= i_op_rd;
                        cnt        <= '0;
                        flush_pend <= 1'b0;
                        if (i_op_en) begin
                            q_mem_req  <= 1'b1;
                            q_mem_we   <= i_op_we;
                            q_mem_addr <= i_op_addr;
                            q_mem_dina <= i_op_data;
                            state      <= S_REQ;
                        end else begin
                            q_p_valid <= 1'b1;
                            q_wb_we   <= 1'b1;
                            q_wb_rd   <= i_op_rd;
                            q_wb_data <= i_op_data;
                            state     <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (req_end) begin
                        q_mem_req <= 1'b0;
                        q_mem_we  <= 1'b0;
                        if (!i_mem_ack) begin
                            q_err_timeout <= 1'b1;
                        end
                        // a flush seen at any point during the access discards its result
                        if (flush_pend || i_p_cp) begin
                            state <= S_IDLE;
                        end else begin
                            state     <= S_DONE;
                            q_p_valid <= 1'b1;
                            q_wb_rd   <= op_rd;
                            q_wb_we   <= i_mem_ack && !q_mem_we;
                            if (i_mem_ack && !q_mem_we) begin
                                q_wb_data <= i_mem_douta;
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (i_p_cp) begin
                            flush_pend <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prco_lsu.sv
// Directed vector bench for prco_lsu (P_TIMEOUT=8): table of single ops
// plus hand sequences for backpressure, timeout, flush and async reset.
module tb_prco_lsu;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_p_cp, i_p_valid, i_p_stalled, i_p_ce;
    logic        q_p_valid, q_p_stalled, q_p_ce;
    logic        i_op_en, i_op_we;
    logic [15:0] i_op_addr, i_op_data;
    logic [2:0]  i_op_rd;
    logic        q_mem_req, q_mem_we;
    logic [15:0] q_mem_addr, q_mem_dina;
    logic        i_mem_ack;
    logic [15:0] i_mem_douta;
    logic        q_wb_we;
    logic [2:0]  q_wb_rd;
    logic [15:0] q_wb_data;
    logic        q_err_timeout;

    always #5 i_clk = ~i_clk;

    prco_lsu #(.P_TIMEOUT(8), .P_RD_WIDTH(3)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_p_cp(i_p_cp),
        .i_p_valid(i_p_valid), .i_p_stalled(i_p_stalled), .i_p_ce(i_p_ce),
        .q_p_valid(q_p_valid), .q_p_stalled(q_p_stalled), .q_p_ce(q_p_ce),
        .i_op_en(i_op_en), .i_op_we(i_op_we), .i_op_addr(i_op_addr),
        .i_op_data(i_op_data), .i_op_rd(i_op_rd),
        .q_mem_req(q_mem_req), .q_mem_we(q_mem_we), .q_mem_addr(q_mem_addr),
        .q_mem_dina(q_mem_dina), .i_mem_ack(i_mem_ack), .i_mem_douta(i_mem_douta),
        .q_wb_we(q_wb_we), .q_wb_rd(q_wb_rd), .q_wb_data(q_wb_data),
        .q_err_timeout(q_err_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic offer(input logic en, input logic we, input logic [15:0] addr,
                         input logic [15:0] data, input logic [2:0] rd);
        i_p_valid = 1'b1;
        i_op_en   = en;
        i_op_we   = we;
        i_op_addr = addr;
        i_op_data = data;
        i_op_rd   = rd;
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    typedef struct {
        logic        en;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] douta;
        logic [2:0]  rd;
        int          ack_at;
        int          exp_req;
        logic        exp_wb_we;
        logic [15:0] exp_wb_data;
        logic        chk_data;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        logic seen_valid;

        vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 3'd2, 3, 3, 1'b1, 16'hBEEF, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 16'h00FF, 16'h1234, 16'h0000, 3'd5, 1, 1, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h00AB, 16'h0000, 3'd1, 0, 0, 1'b1, 16'h00AB, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h8001, 3'd7, 8, 8, 1'b1, 16'h8001, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 1, 1, 1'b1, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 3'd3, 2, 2, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 16'h1111, 16'hFFFF, 16'h0000, 3'd7, 0, 0, 1'b1, 16'hFFFF, 1'b1};

        i_reset = 1'b0;
        i_p_cp = 1'b0; i_p_valid = 1'b0; i_p_stalled = 1'b0; i_p_ce = 1'b1;
        i_op_en = 1'b0; i_op_we = 1'b0; i_op_addr = '0; i_op_data = '0; i_op_rd = '0;
        i_mem_ack = 1'b0; i_mem_douta = '0;
        #1;
        chk("rst_valid", q_p_valid, 0);
        chk("rst_req", q_mem_req, 0);
        chk("rst_wb_we", q_wb_we, 0);
        chk("rst_timeout", q_err_timeout, 0);
        chk("rst_stalled", q_p_stalled, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;

        for (int v = 0; v < 7; v++) begin
            @(negedge i_clk);
            offer(vecs[v].en, vecs[v].we, vecs[v].addr, vecs[v].data, vecs[v].rd);
            #1 chk("capture_ce", q_p_ce, 1);
            step();
            i_p_valid = 1'b0;
            nreq = 0;
            while (q_mem_req && nreq < 50) begin
                nreq++;
                chk("mem_addr", q_mem_addr, vecs[v].addr);
                chk("mem_we", q_mem_we, vecs[v].we);
                if (vecs[v].we) chk("mem_dina", q_mem_dina, vecs[v].data);
                i_mem_ack   = (nreq == vecs[v].ack_at);
                i_mem_douta = i_mem_ack ? vecs[v].douta : 16'hDEAD;
                step();
            end
            i_mem_ack = 1'b0;
            chk("req_cycles", nreq, vecs[v].exp_req);
            chk("done_valid", q_p_valid, 1);
            chk("done_wb_we", q_wb_we, vecs[v].exp_wb_we);
            chk("done_wb_rd", q_wb_rd, vecs[v].rd);
            if (vecs[v].chk_data) chk("done_wb_data", q_wb_data, vecs[v].exp_wb_data);
            step();
            chk("consumed_valid", q_p_valid, 0);
            chk("consumed_wb_we", q_wb_we, 0);
        end
        chk("no_timeout_yet", q_err_timeout, 0);

        // backpressure on a pass-through result
        i_p_ce = 1'b0; i_p_stalled = 1'b1;
        offer(1'b0, 1'b0, 16'h0000, 16'h00AB, 3'd3);
        #1 chk("bp_first_ce", q_p_ce, 1);
        step();
        offer(1'b0, 1'b0, 16'h0000, 16'h5555, 3'd4);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_stalled", q_p_stalled, 1);
            chk("bp_ce", q_p_ce, 0);
            chk("bp_valid", q_p_valid, 1);
            chk("bp_data", q_wb_data, 16'h00AB);
            chk("bp_rd", q_wb_rd, 3'd3);
            step();
        end
        i_p_stalled = 1'b0; i_p_ce = 1'b1;
        #1 chk("bp_release_ce", q_p_ce, 1);
        step();
        i_p_valid = 1'b0;
        chk("bp2_valid", q_p_valid, 1);
        chk("bp2_data", q_wb_data, 16'h5555);
        chk("bp2_rd", q_wb_rd, 3'd4);
        step();
        chk("bp2_consumed", q_p_valid, 0);

        // timeout with no ack
        offer(1'b1, 1'b0, 16'h0040, 16'h0000, 3'd2);
        step();
        i_p_valid = 1'b0;
        nreq = 0;
        while (q_mem_req && nreq < 50) begin
            nreq++;
            chk("to_addr", q_mem_addr, 16'h0040);
            step();
        end
        chk("to_req_cycles", nreq, 8);
        chk("to_flag", q_err_timeout, 1);
        chk("to_valid", q_p_valid, 1);
        chk("to_wb_we", q_wb_we, 0);
        step(); step(); step();
        chk("to_sticky", q_err_timeout, 1);
        chk("to_consumed", q_p_valid, 0);

        // flush on REQ cycle 2, ack on cycle 5
        offer(1'b1, 1'b0, 16'h0020, 16'h0000, 3'd6);
        step();
        i_p_valid = 1'b0;
        nreq = 0;
        seen_valid = 1'b0;
        while (q_mem_req && nreq < 50) begin
            nreq++;
            seen_valid = seen_valid | q_p_valid;
            i_p_cp      = (nreq == 2);
            i_mem_ack   = (nreq == 5);
            i_mem_douta = 16'hCAFE;
            step();
        end
        i_p_cp = 1'b0; i_mem_ack = 1'b0;
        chk("fl_req_cycles", nreq, 5);
        chk("fl_seen_valid", seen_valid, 0);
        chk("fl_valid", q_p_valid, 0);
        chk("fl_wb_we", q_wb_we, 0);
        offer(1'b0, 1'b0, 16'h0000, 16'h0077, 3'd1);
        #1 chk("fl_next_ce", q_p_ce, 1);
        step();
        i_p_valid = 1'b0; i_p_ce = 1'b0;
        chk("fl_next_valid", q_p_valid, 1);
        chk("fl_next_data", q_wb_data, 16'h0077);
        step();
        chk("hold_valid", q_p_valid, 1);

        // flush in IDLE drops held result and blocks the offered op
        offer(1'b0, 1'b0, 16'h0000, 16'h0099, 3'd2);
        i_p_cp = 1'b1;
        step();
        i_p_cp = 1'b0; i_p_valid = 1'b0;
        chk("fli_valid", q_p_valid, 0);
        chk("fli_wb_we", q_wb_we, 0);
        step();
        chk("fli_not_captured", q_p_valid, 0);
        chk("fli_stalled", q_p_stalled, 0);
        i_p_ce = 1'b1;

        // asynchronous reset during REQ
        offer(1'b1, 1'b1, 16'h0030, 16'h4321, 3'd5);
        step();
        i_p_valid = 1'b0;
        step();
        chk("rr_pre_req", q_mem_req, 1);
        #2 i_reset = 1'b0;
        #1;
        chk("rr_req", q_mem_req, 0);
        chk("rr_we", q_mem_we, 0);
        chk("rr_addr", q_mem_addr, 0);
        chk("rr_dina", q_mem_dina, 0);
        chk("rr_timeout", q_err_timeout, 0);
        chk("rr_valid", q_p_valid, 0);
        chk("rr_wb_data", q_wb_data, 0);
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("rr_idle_stalled", q_p_stalled, 0);
        chk("rr_timeout_after", q_err_timeout, 0);
        offer(1'b0, 1'b0, 16'h0000, 16'h0101, 3'd5);
        #1 chk("rr_ce", q_p_ce, 1);
        step();
        i_p_valid = 1'b0;
        chk("rr_op_valid", q_p_valid, 1);
        chk("rr_op_data", q_wb_data, 16'h0101);
        chk("rr_op_rd", q_wb_rd, 3'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
